// File: rtl/xor_arbiter_puf.sv
// XOR arbiter PUF: N_CHAINS arbiter chains raced N_VOTES times per challenge, majority-voted, XOR-combined.
// Optional build macro PUF_TEST_INJECT_EN adds test_mode/test_bits to replace the latch samples.

module xor_arbiter_puf #(
    parameter int N_STAGES      = 128,
    parameter int N_CHAINS      = 4,
    parameter int N_VOTES       = 7,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_STAGES-1:0] challenge,
`ifdef PUF_TEST_INJECT_EN
    input  logic                test_mode,
    input  logic [N_CHAINS-1:0] test_bits,
`endif
    output logic                busy,
    output logic                done,
    output logic                response,
    output logic [N_CHAINS-1:0] chain_resp,
    output logic [N_CHAINS-1:0] unstable
);

    localparam int CW = $clog2(N_VOTES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] HALF_VOTES = CW'(N_VOTES / 2);
    localparam logic [CW-1:0] ALL_VOTES  = CW'(N_VOTES);
    localparam logic [SW-1:0] LAST_CNT   = SW'(SETTLE_CYCLES - 1);

    if (N_VOTES < 1 || (N_VOTES % 2) == 0) begin : g_chk_votes
        $error("xor_arbiter_puf: N_VOTES must be odd and >= 1");
    end
    if (N_CHAINS < 1 || SETTLE_CYCLES < 1 || N_STAGES < 1) begin : g_chk_sizes
        $error("xor_arbiter_puf: N_CHAINS, SETTLE_CYCLES and N_STAGES must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        RELAX  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic                  accept_s;
    logic                  busy_s;
    logic [SW-1:0]         cnt_r;
    logic [CW-1:0]         round_r;
    logic [CW-1:0]         ones_r [N_CHAINS];
    logic [N_STAGES-1:0]   chal_r;
    logic                  launch_r;
    logic [N_CHAINS-1:0]   arb_q_s;
    logic [N_CHAINS-1:0]   sync1_r;
    logic [N_CHAINS-1:0]   sync2_r;
    logic [N_CHAINS-1:0]   sample_s;
    logic [N_CHAINS-1:0]   vote_s;
    logic [N_CHAINS-1:0]   unst_s;
    logic                  busy_r;
    logic                  done_r;
    logic                  response_r;
    logic [N_CHAINS-1:0]   chain_resp_r;
    logic [N_CHAINS-1:0]   unstable_r;

    function automatic logic [N_STAGES-1:0] rotl(input logic [N_STAGES-1:0] x, input int amt);
        logic [N_STAGES-1:0] r;
        r = {N_STAGES{1'b0}};
        for (int i = 0; i < N_STAGES; i++) begin
            r[(i + amt) % N_STAGES] = x[i];
        end
        return r;
    endfunction

    // Each set select bit swaps the two paths; returns 1 when the in0-launched path exits on top.
    function automatic logic in0_on_top(input logic [N_STAGES-1:0] sel);
        logic top;
        top = 1'b1;
        for (int i = 0; i < N_STAGES; i++) begin
            top = top ^ sel[i];
        end
        return top;
    endfunction

    // Both chain inputs share launch_r; the in0 path carries the lead, so the latch sets
    // exactly when that path reaches the top arbiter input.
    for (genvar c = 0; c < N_CHAINS; c++) begin : g_chain
        logic [N_STAGES-1:0] sel_s;
        assign sel_s      = rotl(chal_r, c % N_STAGES);
        assign arb_q_s[c] = launch_r & in0_on_top(sel_s);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= {N_CHAINS{1'b0}};
            sync2_r <= {N_CHAINS{1'b0}};
        end else begin
            sync1_r <= arb_q_s;
            sync2_r <= sync1_r;
        end
    end

    always_comb begin
        sample_s = sync2_r;
`ifdef PUF_TEST_INJECT_EN
        if (test_mode) begin
            sample_s = test_bits;
        end else begin
            sample_s = sync2_r;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Start is also refused while the done pulse is showing, so the DONE cycle never re-arms.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && !done_r) begin
                    state_s  = LAUNCH;
                    accept_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            LAUNCH: state_s = SETTLE;
            SETTLE: begin
                if (cnt_r == LAST_CNT) begin
                    state_s = SAMPLE;
                end else begin
                    state_s = SETTLE;
                end
            end
            SAMPLE: state_s = RELAX;
            RELAX: begin
                if (cnt_r != LAST_CNT) begin
                    state_s = RELAX;
                end else if (round_r < ALL_VOTES) begin
                    state_s = LAUNCH;
                end else begin
                    state_s = DONE;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
        busy_s = (state_s == LAUNCH) || (state_s == SETTLE) ||
                 (state_s == SAMPLE) || (state_s == RELAX);
    end

    always_comb begin
        vote_s = {N_CHAINS{1'b0}};
        unst_s = {N_CHAINS{1'b0}};
        for (int c = 0; c < N_CHAINS; c++) begin
            vote_s[c] = (ones_r[c] > HALF_VOTES);
            unst_s[c] = (ones_r[c] != {CW{1'b0}}) && (ones_r[c] != ALL_VOTES);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r        <= {SW{1'b0}};
            round_r      <= {CW{1'b0}};
            chal_r       <= {N_STAGES{1'b0}};
            launch_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            response_r   <= 1'b0;
            chain_resp_r <= {N_CHAINS{1'b0}};
            unstable_r   <= {N_CHAINS{1'b0}};
            for (int c = 0; c < N_CHAINS; c++) begin
                ones_r[c] <= {CW{1'b0}};
            end
        end else begin
            if (state_s == state_r && (state_r == SETTLE || state_r == RELAX)) begin
                cnt_r <= cnt_r + SW'(1);
            end else begin
                cnt_r <= {SW{1'b0}};
            end
            // Launch rises leaving LAUNCH and stays high through SETTLE and SAMPLE.
            launch_r <= (state_r == LAUNCH) || (state_r == SETTLE);
            busy_r   <= busy_s;
            done_r   <= (state_r == DONE);
            if (accept_s) begin
                chal_r  <= challenge;
                round_r <= {CW{1'b0}};
                for (int c = 0; c < N_CHAINS; c++) begin
                    ones_r[c] <= {CW{1'b0}};
                end
            end else if (state_r == SAMPLE) begin
                round_r <= round_r + CW'(1);
                for (int c = 0; c < N_CHAINS; c++) begin
                    ones_r[c] <= ones_r[c] + CW'(sample_s[c]);
                end
            end
            if (state_r == DONE) begin
                chain_resp_r <= vote_s;
                unstable_r   <= unst_s;
                response_r   <= ^vote_s;
            end
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign response   = response_r;
    assign chain_resp = chain_resp_r;
    assign unstable   = unstable_r;

endmodule
